// File: rtl/morra_pkg.sv
// morra_pkg -- shared definitions for the morra (rock-paper-scissors) sequencer.
//   stato_t      : sequencer FSM states
//   MOSSA_*      : 2-bit move codes exchanged with the players and the core
//   ESITO_*      : 2-bit round / match result codes returned by the core
//   N_MANCHE_MAX : saturation value of the valid-round counter
package morra_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_CONFIG    = 3'd1,
    ST_ATTESA    = 3'd2,
    ST_GIOCA     = 3'd3,
    ST_RISULTATO = 3'd4,
    ST_FINE      = 3'd5
  } stato_t;

  localparam logic [1:0] MOSSA_NULLA   = 2'b00;
  localparam logic [1:0] MOSSA_SASSO   = 2'b01;
  localparam logic [1:0] MOSSA_CARTA   = 2'b10;
  localparam logic [1:0] MOSSA_FORBICE = 2'b11;

  localparam logic [1:0] ESITO_NESSUNO = 2'b00;
  localparam logic [1:0] ESITO_P1      = 2'b01;
  localparam logic [1:0] ESITO_P2      = 2'b10;
  localparam logic [1:0] ESITO_PARI    = 2'b11;

  localparam logic [4:0] N_MANCHE_MAX = 5'd31;

endpackage

// File: rtl/contatore_timeout.sv
// contatore_timeout -- up-counter with synchronous clear and terminal count.
//   clk       : clock
//   rst_n     : synchronous active-low reset
//   clear     : forces the count back to zero (wins over enable)
//   enable    : advance the count by one per cycle
//   terminale : high while the count equals LIMITE-1
// The count stops at LIMITE-1 so terminale stays asserted until cleared.
module contatore_timeout #(
  parameter int unsigned LIMITE = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic terminale
);

  localparam int unsigned W = $clog2(LIMITE + 1);
  localparam logic [W-1:0] ULTIMO = W'(LIMITE - 1);

  logic [W-1:0] conta_q, conta_d;

  assign terminale = (conta_q == ULTIMO);

  always_comb begin
    conta_d = conta_q;
    if (clear) begin
      conta_d = '0;
    end else if (enable && !terminale) begin
      conta_d = conta_q + W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      conta_q <= '0;
    end else begin
      conta_q <= conta_d;
    end
  end

endmodule

// File: rtl/sequenziatore_morra.sv
// sequenziatore_morra -- sequences a morra match between two players and a game core.
//   clk, rst_n                     : clock, synchronous active-low reset
//   avvio                          : one-cycle pulse, (re)starts a match from any state
//   cfg_extra[3:0]                 : extra games, sent to the core during CONFIG
//   pN_mossa/pN_valid/pN_ready     : move handshake of player N (N = 1, 2)
//   core_primo/core_secondo        : moves (or configuration) driven to the core
//   core_inizio                    : high during the configuration cycle
//   core_manche/core_partita       : round and match result from the core
//   esito_valid/esito_manche       : one-cycle round result report
//   n_manche[4:0]                  : valid rounds played, saturating at 31
//   fine/vincitore/occupato        : match finished, winner code, sequencer busy
module sequenziatore_morra
  import morra_pkg::*;
#(
  parameter int unsigned TIMEOUT_CICLI = 16,
  parameter int unsigned GIOCA_CICLI   = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       avvio,
  input  logic [3:0] cfg_extra,
  input  logic [1:0] p1_mossa,
  input  logic       p1_valid,
  output logic       p1_ready,
  input  logic [1:0] p2_mossa,
  input  logic       p2_valid,
  output logic       p2_ready,
  output logic [1:0] core_primo,
  output logic [1:0] core_secondo,
  output logic       core_inizio,
  input  logic [1:0] core_manche,
  input  logic [1:0] core_partita,
  output logic       esito_valid,
  output logic [1:0] esito_manche,
  output logic [4:0] n_manche,
  output logic       fine,
  output logic [1:0] vincitore,
  output logic       occupato
);

  localparam int unsigned GW = $clog2(GIOCA_CICLI + 1);
  localparam logic [GW-1:0] GIOCA_ULT = GW'(GIOCA_CICLI - 1);

  stato_t      stato_q, stato_d;
  logic        cattura1_q, cattura1_d, cattura2_q, cattura2_d;
  logic [1:0]  mossa1_q, mossa1_d, mossa2_q, mossa2_d;
  logic [GW-1:0] gioca_cnt_q, gioca_cnt_d;
  logic [4:0]  n_manche_q, n_manche_d;
  logic [1:0]  vincitore_q, vincitore_d;

  logic pronto1, pronto2, presa1, presa2, entrambe, scaduto, gioca_fine;

  assign pronto1    = (stato_q == ST_ATTESA) && !cattura1_q;
  assign pronto2    = (stato_q == ST_ATTESA) && !cattura2_q;
  assign presa1     = p1_valid && pronto1;
  assign presa2     = p2_valid && pronto2;
  // Both moves available once this cycle's handshakes are taken into account,
  // so the first GIOCA cycle follows the last capture immediately.
  assign entrambe   = (cattura1_q || presa1) && (cattura2_q || presa2);
  assign gioca_fine = (gioca_cnt_q == GIOCA_ULT);

  contatore_timeout #(
    .LIMITE (TIMEOUT_CICLI)
  ) u_timeout (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (stato_q != ST_ATTESA),
    .enable    (stato_q == ST_ATTESA),
    .terminale (scaduto)
  );

  // State register and datapath registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stato_q     <= ST_IDLE;
      cattura1_q  <= 1'b0;
      cattura2_q  <= 1'b0;
      mossa1_q    <= MOSSA_NULLA;
      mossa2_q    <= MOSSA_NULLA;
      gioca_cnt_q <= '0;
      n_manche_q  <= '0;
      vincitore_q <= ESITO_NESSUNO;
    end else begin
      stato_q     <= stato_d;
      cattura1_q  <= cattura1_d;
      cattura2_q  <= cattura2_d;
      mossa1_q    <= mossa1_d;
      mossa2_q    <= mossa2_d;
      gioca_cnt_q <= gioca_cnt_d;
      n_manche_q  <= n_manche_d;
      vincitore_q <= vincitore_d;
    end
  end

  // Next-state logic: avvio restarts the match from any state.
  always_comb begin
    stato_d = stato_q;
    if (avvio) begin
      stato_d = ST_CONFIG;
    end else begin
      case (stato_q)
        ST_IDLE:      stato_d = ST_IDLE;
        ST_CONFIG:    stato_d = ST_ATTESA;
        ST_ATTESA:    if (entrambe || scaduto) stato_d = ST_GIOCA;
        ST_GIOCA:     if (gioca_fine) stato_d = ST_RISULTATO;
        ST_RISULTATO: stato_d = (core_partita != ESITO_NESSUNO) ? ST_FINE : ST_ATTESA;
        ST_FINE:      stato_d = ST_FINE;
        default:      stato_d = ST_IDLE;
      endcase
    end
  end

  // Datapath next values
  always_comb begin
    cattura1_d  = cattura1_q;
    cattura2_d  = cattura2_q;
    mossa1_d    = mossa1_q;
    mossa2_d    = mossa2_q;
    gioca_cnt_d = '0;
    n_manche_d  = n_manche_q;
    vincitore_d = vincitore_q;
    if (stato_d == ST_CONFIG) begin
      // Entering (or restarting) configuration drops everything in flight,
      // so CONFIG already shows n_manche = 0.
      cattura1_d  = 1'b0;
      cattura2_d  = 1'b0;
      mossa1_d    = MOSSA_NULLA;
      mossa2_d    = MOSSA_NULLA;
      n_manche_d  = '0;
      vincitore_d = ESITO_NESSUNO;
    end else begin
      case (stato_q)
        ST_ATTESA: begin
          if (presa1) begin
            cattura1_d = 1'b1;
            mossa1_d   = p1_mossa;
          end
          if (presa2) begin
            cattura2_d = 1'b1;
            mossa2_d   = p2_mossa;
          end
          if (scaduto && !entrambe) begin
            if (!cattura1_q && !presa1) mossa1_d = MOSSA_NULLA;
            if (!cattura2_q && !presa2) mossa2_d = MOSSA_NULLA;
          end
        end
        ST_GIOCA: begin
          gioca_cnt_d = gioca_fine ? '0 : gioca_cnt_q + GW'(1);
        end
        ST_RISULTATO: begin
          if (core_manche != ESITO_NESSUNO && n_manche_q != N_MANCHE_MAX) begin
            n_manche_d = n_manche_q + 5'd1;
          end
          if (core_partita != ESITO_NESSUNO) begin
            vincitore_d = core_partita;
          end
          cattura1_d = 1'b0;
          cattura2_d = 1'b0;
          mossa1_d   = MOSSA_NULLA;
          mossa2_d   = MOSSA_NULLA;
        end
        default: ;
      endcase
    end
  end

  // Outputs decoded from the current state
  always_comb begin
    p1_ready     = 1'b0;
    p2_ready     = 1'b0;
    core_primo   = MOSSA_NULLA;
    core_secondo = MOSSA_NULLA;
    core_inizio  = 1'b0;
    esito_valid  = 1'b0;
    esito_manche = ESITO_NESSUNO;
    fine         = 1'b0;
    occupato     = 1'b1;
    case (stato_q)
      ST_IDLE: occupato = 1'b0;
      ST_CONFIG: begin
        core_inizio  = 1'b1;
        core_primo   = cfg_extra[3:2];
        core_secondo = cfg_extra[1:0];
      end
      ST_ATTESA: begin
        p1_ready = pronto1;
        p2_ready = pronto2;
      end
      ST_GIOCA: begin
        core_primo   = mossa1_q;
        core_secondo = mossa2_q;
      end
      ST_RISULTATO: begin
        esito_valid  = 1'b1;
        esito_manche = core_manche;
      end
      ST_FINE: begin
        fine     = 1'b1;
        occupato = 1'b0;
      end
      default: occupato = 1'b0;
    endcase
  end

  assign n_manche  = n_manche_q;
  assign vincitore = vincitore_q;

endmodule

// File: tb/tb_sequenziatore_morra.sv
module tb_sequenziatore_morra;

  logic       clk = 1'b0;
  logic       rst_n, avvio;
  logic [3:0] cfg_extra;
  logic [1:0] p1_mossa, p2_mossa;
  logic       p1_valid, p2_valid, p1_ready, p2_ready;
  logic [1:0] core_primo, core_secondo;
  logic       core_inizio;
  logic [1:0] core_manche, core_partita;
  logic       esito_valid;
  logic [1:0] esito_manche;
  logic [4:0] n_manche;
  logic       fine, occupato;
  logic [1:0] vincitore;

  always #5 clk = ~clk;

  sequenziatore_morra #(
    .TIMEOUT_CICLI (16),
    .GIOCA_CICLI   (2)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .avvio        (avvio),
    .cfg_extra    (cfg_extra),
    .p1_mossa     (p1_mossa),
    .p1_valid     (p1_valid),
    .p1_ready     (p1_ready),
    .p2_mossa     (p2_mossa),
    .p2_valid     (p2_valid),
    .p2_ready     (p2_ready),
    .core_primo   (core_primo),
    .core_secondo (core_secondo),
    .core_inizio  (core_inizio),
    .core_manche  (core_manche),
    .core_partita (core_partita),
    .esito_valid  (esito_valid),
    .esito_manche (esito_manche),
    .n_manche     (n_manche),
    .fine         (fine),
    .vincitore    (vincitore),
    .occupato     (occupato)
  );

  typedef struct {
    logic [1:0] m1;
    logic [1:0] m2;
    logic [1:0] esito;
    int         n;
    bit         fine;
    logic [1:0] vin;
    int         attesa;
  } exp_t;

  exp_t sb[$];
  int   vectors = 0;
  int   miscompares = 0;
  int   n_model = 0;
  int   n_round = 0;

  task automatic chk(input string nome, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nome, act, req, $time);
    end
  endtask

  task automatic bound_expired(input string nome);
    vectors++;
    miscompares++;
    $display("FAIL %s: wait bound expired (t=%0t)", nome, $time);
  endtask

  // Rock-paper-scissors rules: any NULLA voids the round, equal moves draw,
  // otherwise a move beats the one just below it in cyclic order.
  function automatic logic [1:0] rps(input logic [1:0] a, input logic [1:0] b);
    int d;
    if (a == 2'd0 || b == 2'd0) return 2'd0;
    if (a == b) return 2'd3;
    d = (int'(a) - int'(b) + 3) % 3;
    return (d == 1) ? 2'd1 : 2'd2;
  endfunction

  // Monitor: classifies each cycle from the visible outputs and checks every
  // round report against the next scoreboard entry.
  initial begin : monitor
    exp_t e, pend_e;
    bit pend = 0;
    int att = 0;
    int gio = 0;
    bit gstab = 1;
    logic [1:0] g1 = 2'd0, g2 = 2'd0;
    forever begin
      @(negedge clk);
      if (pend) begin
        chk("n_manche_post", 32'(n_manche), 32'(pend_e.n));
        chk("fine_post", 32'(fine), 32'(pend_e.fine));
        chk("vincitore_post", 32'(vincitore), 32'(pend_e.vin));
        chk("occupato_post", 32'(occupato), 32'(!pend_e.fine));
        pend = 0;
      end
      if (!rst_n || !occupato || core_inizio) begin
        att = 0; gio = 0; gstab = 1;
      end else if (esito_valid) begin
        if (sb.size() == 0) begin
          bound_expired("esito_inatteso");
        end else begin
          e = sb.pop_front();
          n_round++;
          $display("manche %0d: mosse %0d/%0d esito %0d attesa %0d n_manche atteso %0d",
                   n_round, e.m1, e.m2, e.esito, e.attesa, e.n);
          chk("esito_manche", 32'(esito_manche), 32'(e.esito));
          chk("mosse_core", 32'({g1, g2}), 32'({e.m1, e.m2}));
          chk("cicli_gioca", 32'(gio), 32'd2);
          chk("gioca_stabile", 32'(gstab), 32'd1);
          chk("cicli_attesa", 32'(att), 32'(e.attesa));
          pend_e = e;
          pend = 1;
        end
        att = 0; gio = 0; gstab = 1;
      end else if (p1_ready || p2_ready) begin
        att++;
      end else begin
        if (gio == 0) begin
          g1 = core_primo;
          g2 = core_secondo;
        end else if ({core_primo, core_secondo} != {g1, g2}) begin
          gstab = 0;
        end
        gio++;
      end
    end
  end

  task automatic wait_attesa();
    int k = 0;
    while (!(p1_ready || p2_ready) && k < 60) begin
      @(negedge clk);
      k++;
    end
    if (!(p1_ready || p2_ready)) bound_expired("attesa_mai_raggiunta");
  endtask

  task automatic gioca_p1(input int d, input logic [1:0] m);
    repeat (d) @(negedge clk);
    p1_mossa = m;
    p1_valid = 1'b1;
    @(negedge clk);
    p1_valid = 1'b0;
    p1_mossa = 2'd0;
    chk("p1_ready_dopo_cattura", 32'(p1_ready), 32'd0);
  endtask

  task automatic gioca_p2(input int d, input logic [1:0] m);
    repeat (d) @(negedge clk);
    p2_mossa = m;
    p2_valid = 1'b1;
    @(negedge clk);
    p2_valid = 1'b0;
    p2_mossa = 2'd0;
    chk("p2_ready_dopo_cattura", 32'(p2_ready), 32'd0);
  endtask

  task automatic start_match(input logic [3:0] cfg);
    avvio = 1'b1;
    cfg_extra = cfg;
    @(negedge clk);
    chk("config_inizio", 32'(core_inizio), 32'd1);
    chk("config_primo", 32'(core_primo), 32'(cfg[3:2]));
    chk("config_secondo", 32'(core_secondo), 32'(cfg[1:0]));
    chk("config_n_manche", 32'(n_manche), 32'd0);
    chk("config_fine_vinc", 32'({fine, vincitore}), 32'd0);
    chk("config_occupato", 32'(occupato), 32'd1);
    avvio = 1'b0;
    n_model = 0;
  endtask

  task automatic do_round(input bit pr1, input bit pr2, input logic [1:0] m1, input logic [1:0] m2,
                          input int d1, input int d2, input logic [1:0] partita);
    exp_t e;
    int k;
    e.m1 = pr1 ? m1 : 2'd0;
    e.m2 = pr2 ? m2 : 2'd0;
    e.esito = rps(e.m1, e.m2);
    if (e.esito != 2'd0 && n_model < 31) n_model++;
    e.n = n_model;
    e.fine = (partita != 2'd0);
    e.vin = partita;
    e.attesa = (pr1 && pr2) ? (((d1 > d2) ? d1 : d2) + 1) : 16;
    core_manche = e.esito;
    core_partita = partita;
    sb.push_back(e);
    wait_attesa();
    fork
      begin if (pr1) gioca_p1(d1, m1); end
      begin if (pr2) gioca_p2(d2, m2); end
    join
    k = 0;
    while (!esito_valid && k < 60) begin
      @(negedge clk);
      k++;
    end
    if (!esito_valid) bound_expired("esito_mai_visto");
    @(negedge clk);
  endtask

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin : stimolo
    int nr;
    rst_n = 1'b0; avvio = 1'b0; cfg_extra = 4'd0;
    p1_mossa = 2'd0; p2_mossa = 2'd0; p1_valid = 1'b0; p2_valid = 1'b0;
    core_manche = 2'd0; core_partita = 2'd0;
    repeat (3) @(negedge clk);
    chk("reset_uscite", 32'({p1_ready, p2_ready, core_primo, core_secondo, core_inizio, esito_valid,
                             esito_manche, n_manche, fine, vincitore, occupato}), 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("idle_fermo", 32'({occupato, core_inizio, p1_ready, p2_ready}), 32'd0);

    // Directed: configuration, CARTA vs SASSO, single-player timeout, end of match.
    start_match(4'b0011);
    @(negedge clk);
    chk("attesa_ready_entrambi", 32'({p1_ready, p2_ready}), 32'b11);
    do_round(1, 1, 2'b10, 2'b01, 0, 0, 2'b00);
    do_round(1, 0, 2'b11, 2'b00, 2, 0, 2'b00);
    do_round(1, 1, 2'b01, 2'b10, 1, 3, 2'b10);
    repeat (3) @(negedge clk);
    chk("fine_tenuta", 32'({fine, vincitore, occupato}), 32'({1'b1, 2'b10, 1'b0}));

    // Randomized matches
    for (int mt = 0; mt < 4; mt++) begin
      start_match(4'($urandom_range(0, 15)));
      nr = $urandom_range(3, 8);
      for (int r = 0; r < nr; r++) begin
        do_round($urandom_range(0, 4) != 0, $urandom_range(0, 4) != 0,
                 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                 $urandom_range(0, 5), $urandom_range(0, 5),
                 (r == nr - 1) ? 2'($urandom_range(1, 3)) : 2'd0);
      end
    end

    // Long match: n_manche saturates at 31
    start_match(4'b1111);
    for (int r = 0; r < 34; r++) begin
      do_round(1, 1, 2'($urandom_range(1, 3)), 2'($urandom_range(1, 3)),
               $urandom_range(0, 2), $urandom_range(0, 2), (r == 33) ? 2'b11 : 2'b00);
    end

    // Abort during GIOCA
    start_match(4'b0110);
    do_round(1, 1, 2'b10, 2'b01, 0, 1, 2'b00);
    wait_attesa();
    fork
      gioca_p1(0, 2'b11);
      gioca_p2(0, 2'b10);
    join
    chk("gioca_prima_di_abort", 32'({core_primo, core_secondo, core_inizio}), 32'({2'b11, 2'b10, 1'b0}));
    avvio = 1'b1;
    @(negedge clk);
    chk("abort_config", 32'({core_inizio, core_primo, core_secondo}), 32'({1'b1, 4'b0110}));
    chk("abort_n_manche", 32'(n_manche), 32'd0);
    avvio = 1'b0;
    @(negedge clk);
    chk("abort_catture_pulite", 32'({p1_ready, p2_ready, core_primo, core_secondo}), 32'({2'b11, 4'b0000}));

    // Reset in ATTESA with one move captured; reset beats avvio and valid
    p1_mossa = 2'b01;
    p1_valid = 1'b1;
    @(negedge clk);
    p1_valid = 1'b0;
    chk("una_mossa_presa", 32'({p1_ready, p2_ready}), 32'b01);
    rst_n = 1'b0;
    avvio = 1'b1;
    p2_mossa = 2'b10;
    p2_valid = 1'b1;
    @(negedge clk);
    chk("reset_in_attesa", 32'({p1_ready, p2_ready, core_primo, core_secondo, core_inizio, esito_valid,
                                esito_manche, n_manche, fine, vincitore, occupato}), 32'd0);
    avvio = 1'b0;
    p2_valid = 1'b0;
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("idle_dopo_reset", 32'({occupato, p1_ready, p2_ready, n_manche}), 32'd0);

    repeat (3) @(negedge clk);
    chk("scoreboard_vuoto", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/sequenziatore_morra.md
SEQUENZIATORE_MORRA -- requirements
Module: sequenziatore_morra

Interface
REQ-001 SHALL have parameter TIMEOUT_CICLI, default 16: cycles allowed in ATTESA before missing moves are forced to NULLA.
REQ-002 SHALL have parameter GIOCA_CICLI, default 2: cycles the captured moves are held on the core before the result is sampled.
REQ-003 SHALL have port clk, input, 1 bit: the single clock, with all state updated on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: synchronous, active-low reset.
REQ-005 SHALL have port avvio, input, 1 bit: one-cycle pulse that starts a new match.
REQ-006 SHALL have port cfg_extra, input, 4 bits: extra games beyond the minimum of 4, passed to the core at start.
REQ-007 SHALL have ports p1_mossa (input, 2), p1_valid (input, 1), p1_ready (output, 1): player-1 move handshake.
REQ-008 SHALL have ports p2_mossa (input, 2), p2_valid (input, 1), p2_ready (output, 1): player-2 move handshake.
REQ-009 SHALL have ports core_primo (output, 2), core_secondo (output, 2), core_inizio (output, 1): drive to the game core.
REQ-010 SHALL have ports core_manche (input, 2) and core_partita (input, 2): round and match result from the core.
REQ-011 SHALL have ports esito_valid (output, 1) and esito_manche (output, 2): round result report.
REQ-012 SHALL have port n_manche, output, 5 bits: count of valid rounds played.
REQ-013 SHALL have ports fine (output, 1), vincitore (output, 2), occupato (output, 1): match status.

Function
REQ-014 Move codes SHALL be: 00 NULLA (invalid), 01 SASSO, 10 CARTA, 11 FORBICE.
REQ-015 FSM states SHALL be IDLE, CONFIG, ATTESA, GIOCA, RISULTATO, FINE.
REQ-016 IDLE SHALL go to CONFIG when avvio=1; otherwise it holds.
REQ-017 CONFIG SHALL last exactly 1 cycle, driving core_inizio=1 and {core_primo,core_secondo}=cfg_extra, clearing n_manche, fine and vincitore, then go to ATTESA.
REQ-018 In ATTESA, pN_ready SHALL be 1 only while player N's move is not yet captured.
REQ-019 A move SHALL be captured on a cycle with pN_valid & pN_ready; both players SHALL be capturable in the same cycle.
REQ-020 ATTESA SHALL go to GIOCA on the cycle after both moves are captured.
REQ-021 The ATTESA timeout counter SHALL reset on entry; if it reaches TIMEOUT_CICLI-1 with a move still missing, the missing move(s) SHALL be set to NULLA and the FSM SHALL go to GIOCA.
REQ-022 GIOCA SHALL drive the captured moves on core_primo/core_secondo for GIOCA_CICLI cycles, then go to RISULTATO.
REQ-023 In every state other than CONFIG and GIOCA, core_primo/core_secondo SHALL be 00.
REQ-024 RISULTATO SHALL last 1 cycle, with esito_valid=1 and esito_manche=core_manche.
REQ-025 If core_manche≠00 in RISULTATO, n_manche SHALL increment, saturating at 31.
REQ-026 From RISULTATO, if core_partita≠00 the FSM SHALL go to FINE and latch vincitore=core_partita; otherwise it SHALL go to ATTESA with both captures cleared.
REQ-027 FINE SHALL hold fine=1 and vincitore until avvio.
REQ-028 avvio=1 in any non-IDLE state, including FINE, SHALL abort the current round (discarding captures) and go to CONFIG next cycle.
REQ-029 occupato SHALL be 1 in every state except IDLE and FINE.
REQ-030 esito_valid SHALL be 0 outside RISULTATO.
REQ-031 Input-to-core latency SHALL be 1 cycle from the capture of the last move to the first GIOCA cycle.

Reset
REQ-032 rst_n=0 at a clock edge SHALL force IDLE, clear both captures and the timeout counter, and set every output to 0.
REQ-033 Reset SHALL take priority over avvio and every in-flight handshake.

Structure
REQ-034 Package morra_pkg SHALL hold the state enum, move-code constants and result codes (00 none, 01 P1, 10 P2, 11 draw).
REQ-035 The timeout counter SHALL be a sub-module contatore_timeout (clear, enable, terminal-count output).
REQ-036 Size SHALL be ceil(log2(TIMEOUT_CICLI+1)) for the timeout counter and ceil(log2(GIOCA_CICLI+1)) for the GIOCA counter.

Verification
REQ-037 Reset, then avvio with cfg_extra=0011 -> 1 cycle of core_inizio=1 with core_primo=00 and core_secondo=11, then p1_ready=p2_ready=1.
REQ-038 p1=CARTA and p2=SASSO, both valid in the same cycle -> core driven 10/01 for 2 cycles; core_manche=01 gives esito_valid for 1 cycle with esito_manche=01 and n_manche=1.
REQ-039 Only p1 valid -> p1_ready drops, p2_ready stays 1; after 16 cycles core_secondo=00 and a NULLA round with n_manche unchanged.
REQ-040 core_partita=10 in RISULTATO -> FINE with fine=1, vincitore=10, occupato=0, held until avvio.
REQ-041 avvio pulsed during GIOCA -> next cycle CONFIG with core_inizio=1, captures cleared and n_manche=0.
REQ-042 rst_n=0 mid-ATTESA with one move captured -> next cycle IDLE with all outputs 0.
